// File: rtl/cpu_sim_pkg.sv
// rtl/cpu_sim_pkg.sv - shared types and constants for the CPU run controller
// Purpose: run-controller state encoding, end-of-run cause encoding and the
//          default halt instruction word (beq $0,$0,-1).
// Ports:   none (package).
package cpu_sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_HALT    = 2'd1,
    CAUSE_STALL   = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } end_cause_e;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h1000_FFFF;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear
// Purpose: counts up by one per inc, sticks at all-ones, never wraps.
//          clr and inc together load 1 (restart the count with this event).
// Ports:   clk   - clock
//          rst   - synchronous active-high reset
//          clr   - clear the count
//          inc   - increment the count
//          count - registered count value
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU reset-hold / run-budget / termination controller
// Purpose: holds the core in reset for RESET_CYCLES after start, runs it under
//          a MAX_CYCLES budget, ends the run on halt instruction, stuck PC or
//          budget exhaustion, and reports status plus cycle/retire counters.
// Ports:   clock        - clock
//          rst_n        - synchronous active-high reset (name matches CPU top)
//          start        - run request pulse, honoured in IDLE/DONE only
//          instr_valid  - core retired an instruction this cycle
//          instruction  - retired instruction word
//          pc           - PC of the retired instruction
//          core_rst     - active-high reset to the core
//          running      - RUN state
//          done         - run finished, held until next start or reset
//          halt_hit/timeout/stall_err - end cause, exactly one per run
//          cycle_count  - RUN cycles this run
//          instr_count  - valid retirements this run
module cpu_run_ctrl
  import cpu_sim_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 125,
  parameter int unsigned STALL_LIMIT  = 16,
  parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEFAULT,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic             instr_valid,
  input  logic [31:0]      instruction,
  input  logic [31:0]      pc,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             halt_hit,
  output logic             timeout,
  output logic             stall_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned REP_W  = $clog2(STALL_LIMIT + 1);

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       last_pc_q, last_pc_d;
  logic              done_q, done_d;
  logic              halt_hit_q, halt_hit_d;
  logic              timeout_q, timeout_d;
  logic              stall_err_q, stall_err_d;

  logic              in_run;
  logic              start_acc;
  logic              same_pc;
  logic              rep_clr;
  logic [REP_W-1:0]  rep_cnt;
  end_cause_e        cause;

  assign in_run = (state_q == ST_RUN);

  // A zero repeat count means no retirement yet this run, so the stale
  // last_pc from a previous run can never extend a repeat streak.
  assign same_pc = (rep_cnt != '0) && (pc == last_pc_q);
  assign rep_clr = start_acc || (in_run && instr_valid && !same_pc);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clock), .rst(rst_n), .clr(start_acc), .inc(in_run), .count(cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk(clock), .rst(rst_n), .clr(start_acc), .inc(in_run && instr_valid),
    .count(instr_count)
  );

  // clr+inc loads 1: a new pc starts a fresh streak of length one.
  sat_counter #(.W(REP_W)) u_repeat_cnt (
    .clk(clock), .rst(rst_n), .clr(rep_clr), .inc(in_run && instr_valid),
    .count(rep_cnt)
  );

  always_comb begin
    last_pc_d = last_pc_q;
    if (in_run && instr_valid) begin
      last_pc_d = pc;
    end
  end

  // Events are judged on the values the counters take at this edge, hence
  // the compares against LIMIT-1 on the pre-increment counts.
  always_comb begin
    cause = CAUSE_NONE;
    if (instr_valid && (instruction == HALT_INSTR)) begin
      cause = CAUSE_HALT;
    end else if (instr_valid && same_pc && (rep_cnt == REP_W'(STALL_LIMIT - 1))) begin
      cause = CAUSE_STALL;
    end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
      cause = CAUSE_TIMEOUT;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    done_d      = done_q;
    halt_hit_d  = halt_hit_q;
    timeout_d   = timeout_q;
    stall_err_d = stall_err_q;
    start_acc   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RESET;
          hold_d      = HOLD_W'(RESET_CYCLES - 1);
          start_acc   = 1'b1;
          done_d      = 1'b0;
          halt_hit_d  = 1'b0;
          timeout_d   = 1'b0;
          stall_err_d = 1'b0;
        end
      end
      ST_RESET: begin
        if (hold_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (cause != CAUSE_NONE) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          halt_hit_d  = (cause == CAUSE_HALT);
          stall_err_d = (cause == CAUSE_STALL);
          timeout_d   = (cause == CAUSE_TIMEOUT);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      last_pc_q   <= '0;
      done_q      <= 1'b0;
      halt_hit_q  <= 1'b0;
      timeout_q   <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      last_pc_q   <= last_pc_d;
      done_q      <= done_d;
      halt_hit_q  <= halt_hit_d;
      timeout_q   <= timeout_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign running   = in_run;
  assign core_rst  = !in_run;
  assign done      = done_q;
  assign halt_hit  = halt_hit_q;
  assign timeout   = timeout_q;
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;
  import cpu_sim_pkg::*;

  localparam int unsigned RC   = 4;
  localparam int unsigned MAXC = 125;
  localparam int unsigned SL   = 16;
  localparam logic [31:0] HALT = 32'h1000_FFFF;

  logic        clock = 1'b0;
  logic        rst_n, start, instr_valid;
  logic [31:0] instruction, pc;
  logic        core_rst, running, done, halt_hit, timeout, stall_err;
  logic [31:0] cycle_count, instr_count;

  int total = 0;
  int bad   = 0;

  bit          v_a [1:MAXC];
  logic [31:0] i_a [1:MAXC];
  logic [31:0] p_a [1:MAXC];

  always #5 clock = ~clock;

  cpu_run_ctrl #(
    .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .STALL_LIMIT(SL),
    .HALT_INSTR(HALT), .CNT_W(32)
  ) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .instr_valid(instr_valid),
    .instruction(instruction), .pc(pc), .core_rst(core_rst), .running(running),
    .done(done), .halt_hit(halt_hit), .timeout(timeout), .stall_err(stall_err),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = ~w;
    return w;
  endfunction

  // all_valid=1: retire every cycle; otherwise random gaps. PCs always change.
  task automatic fill_distinct(input bit all_valid);
    logic [31:0] base;
    base = {$urandom_range(0, 255), 12'h000, 4'h0};
    for (int k = 1; k <= int'(MAXC); k++) begin
      v_a[k] = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
      i_a[k] = rand_instr();
      p_a[k] = base + 32'(4 * k);
    end
  endtask

  // PC mostly sticks, occasionally moves; rare halts.
  task automatic fill_random();
    logic [31:0] cur;
    cur = 32'h0000_1000;
    for (int k = 1; k <= int'(MAXC); k++) begin
      if ($urandom_range(0, 15) == 0) cur = cur + 32'd4;
      v_a[k] = ($urandom_range(0, 3) != 0);
      i_a[k] = ($urandom_range(0, 99) == 0) ? HALT : rand_instr();
      p_a[k] = cur;
    end
  endtask

  // Reference: walk the RUN cycles in order applying the end rules directly.
  task automatic predict(output int end_k, output end_cause_e cause, output int icnt);
    int          rep;
    int          ic;
    logic [31:0] lpc;
    rep = 0; ic = 0; lpc = '0;
    end_k = MAXC; cause = CAUSE_TIMEOUT; icnt = 0;
    for (int k = 1; k <= int'(MAXC); k++) begin
      if (v_a[k]) begin
        ic++;
        rep = (rep > 0 && p_a[k] == lpc) ? rep + 1 : 1;
        lpc = p_a[k];
      end
      icnt = ic;
      if (v_a[k] && i_a[k] == HALT) begin
        end_k = k; cause = CAUSE_HALT; break;
      end
      if (v_a[k] && rep == int'(SL)) begin
        end_k = k; cause = CAUSE_STALL; break;
      end
      if (k == int'(MAXC)) begin
        end_k = k; cause = CAUSE_TIMEOUT; break;
      end
    end
  endtask

  task automatic do_run(input string tag);
    int         end_k, icnt, seen;
    end_cause_e cause;
    predict(end_k, cause, icnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ":clr_cyc"}, cycle_count, 32'd0);
    chk({tag, ":clr_ins"}, instr_count, 32'd0);
    chk({tag, ":clr_done"}, 32'(done), 32'd0);
    instr_valid = 1'b1;
    instruction = HALT;
    pc = 32'h0;
    for (int i = 0; i < int'(RC); i++) begin
      chk({tag, ":hold_rst"}, 32'(core_rst), 32'd1);
      chk({tag, ":hold_run"}, 32'(running), 32'd0);
      tick();
    end
    chk({tag, ":run_on"}, 32'(running), 32'd1);
    chk({tag, ":run_rst"}, 32'(core_rst), 32'd0);
    seen = 0;
    for (int k = 1; k <= int'(MAXC) + 4 && seen == 0; k++) begin
      if (k <= int'(MAXC)) begin
        instr_valid = v_a[k]; instruction = i_a[k]; pc = p_a[k];
      end else begin
        instr_valid = 1'b0;
      end
      tick();
      if (done) seen = k;
    end
    instr_valid = 1'b0;
    chk({tag, ":end_cycle"}, 32'(seen), 32'(end_k));
    chk({tag, ":cyc"}, cycle_count, 32'(end_k));
    chk({tag, ":ins"}, instr_count, 32'(icnt));
    chk({tag, ":halt"}, 32'(halt_hit), 32'(cause == CAUSE_HALT));
    chk({tag, ":stall"}, 32'(stall_err), 32'(cause == CAUSE_STALL));
    chk({tag, ":tmo"}, 32'(timeout), 32'(cause == CAUSE_TIMEOUT));
    chk({tag, ":done_rst"}, 32'(core_rst), 32'd1);
    chk({tag, ":done_run"}, 32'(running), 32'd0);
    instr_valid = 1'b1;
    instruction = HALT;
    tick();
    tick();
    instr_valid = 1'b0;
    chk({tag, ":hold_cyc"}, cycle_count, 32'(end_k));
    chk({tag, ":hold_ins"}, instr_count, 32'(icnt));
    chk({tag, ":hold_done"}, 32'(done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, ":running"}, 32'(running), 32'd0);
    chk({tag, ":done"}, 32'(done), 32'd0);
    chk({tag, ":flags"}, 32'({halt_hit, timeout, stall_err}), 32'd0);
    chk({tag, ":cyc"}, cycle_count, 32'd0);
    chk({tag, ":ins"}, instr_count, 32'd0);
  endtask

  initial begin
    int vcount;
    rst_n = 1'b1; start = 1'b0; instr_valid = 1'b0; instruction = '0; pc = '0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst_n = 1'b0;
    tick();
    chk_reset_vals("idle");

    fill_distinct(1'b1);
    i_a[11] = HALT;
    do_run("halt");

    fill_distinct(1'b0);
    do_run("timeout");

    fill_distinct(1'b1);
    for (int k = 1; k <= int'(MAXC); k++) p_a[k] = 32'h0000_0040;
    do_run("stall");

    fill_distinct(1'b0);
    v_a[MAXC] = 1'b1;
    i_a[MAXC] = HALT;
    do_run("coincide");

    for (int r = 0; r < 4; r++) begin
      fill_random();
      do_run($sformatf("rand%0d", r));
    end

    fill_distinct(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RC) tick();
    vcount = 0;
    for (int k = 1; k <= 50; k++) begin
      instr_valid = v_a[k]; instruction = i_a[k]; pc = p_a[k];
      if (v_a[k]) vcount++;
      tick();
    end
    instr_valid = 1'b0;
    chk("mid:cyc50", cycle_count, 32'd50);
    chk("mid:ins50", instr_count, 32'(vcount));
    chk("mid:running", 32'(running), 32'd1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk_reset_vals("midrst");

    fill_distinct(1'b1);
    i_a[7] = HALT;
    do_run("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Parametrised run controller for the CPU core that replaces a fixed reset-then-free-run sequence. It holds the core in reset for a configurable number of cycles and lets it run under a cycle budget. It detects program termination (halt instruction or stuck PC) and reports done, halt, timeout and stall status plus cycle and retired-instruction counters. It sits between the board or bench reset/start and the top-level CPU reset input. The benches use the status outputs to decide end-of-simulation.

Parameters:
RESET_CYCLES, 4, cycles core_rst is held high after start (min 1)
MAX_CYCLES, 125, RUN-state cycle budget before timeout (min 1)
STALL_LIMIT, 16, consecutive valid retirements with unchanged pc that flag a stall (min 2)
HALT_INSTR, 32'h1000_FFFF, instruction word treated as program end (beq $0,$0,-1)
CNT_W, 32, width of cycle_count/instr_count

Ports:
clock  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-high reset; port name kept to match the CPU top
start  in  1  one-cycle pulse that begins a run; ignored outside IDLE/DONE
instr_valid  in  1  core retired an instruction this cycle
instruction  in  32  retired instruction word, qualified by instr_valid
pc  in  32  PC of the retired instruction, qualified by instr_valid
core_rst  out  1  active-high reset to the CPU core
running  out  1  high in RUN
done  out  1  high in DONE, held until next start or rst_n
halt_hit  out  1  run ended on HALT_INSTR
timeout  out  1  run ended on budget exhaustion
stall_err  out  1  run ended on stuck PC
cycle_count  out  CNT_W  cycles spent in RUN this run
instr_count  out  CNT_W  valid retirements this run

Behaviour:
- rst_n=1 at a clock edge: state=IDLE; core_rst=1; running=done=halt_hit=timeout=stall_err=0; all counters=0. rst_n takes priority over every other input, including mid-RUN.
- IDLE: core_rst=1. start -> RESET, reset-hold counter loaded with RESET_CYCLES-1. Counters and flags clear on the same edge.
- RESET: core_rst=1 for exactly RESET_CYCLES cycles. At counter 0 -> RUN. start is ignored.
- RUN: core_rst=0 and running=1. On every edge, cycle_count+1. On a valid retirement, instr_count+1. Counters saturate at all-ones and never wrap.
- Halt: instr_valid and instruction==HALT_INSTR -> DONE with halt_hit=1. The halt instruction is counted in instr_count.
- Stall: track last_pc and a repeat counter. Valid retirement with pc==last_pc: repeat+1. Valid retirement with a different pc: repeat=1. The first valid retirement of a run sets repeat=1. repeat reaching STALL_LIMIT -> DONE with stall_err=1. Cycles with instr_valid=0 do not touch repeat.
- Timeout: cycle_count reaching MAX_CYCLES (the edge on which it becomes MAX_CYCLES) -> DONE with timeout=1.
- Priority when events coincide on one edge: halt > stall > timeout. Exactly one flag is set per run.
- DONE: core_rst=1 (core frozen), running=0, done=1. Counters and flags hold. start -> RESET, clearing counters and flags (rerun).
- Outputs are registered, with one-cycle latency from the causing edge. Exception: running and core_rst decode directly from the state register.
- The stall check uses an unsigned 32-bit compare; there is no pc alignment check.
- An instr_valid pulse outside RUN is ignored.

Decomposition:
- Shared package cpu_sim_pkg: state enum (IDLE, RESET, RUN, DONE), HALT_INSTR default, end-cause encoding (NONE, HALT, STALL, TIMEOUT) reused by the bench scoreboard.
- One sub-module, sat_counter (parametrised width, clear/inc, saturating). It is instantiated for cycle_count, instr_count and the stall repeat counter.
- FSM and event priority stay in cpu_run_ctrl.

Test Plan:
- Reset/hold: rst_n=1 for 2 cycles, then start pulse, defaults -> core_rst high exactly 4 cycles after start edge, then running=1.
- Halt: feed 10 valid distinct-pc instructions, then instruction=32'h1000_FFFF -> done=1, halt_hit=1, instr_count=11, timeout=stall_err=0.
- Timeout: no halt, distinct pcs, MAX_CYCLES=125 -> done on the 125th RUN cycle, cycle_count=125, timeout=1.
- Stall: pc stuck at 32'h0000_0040 with instr_valid every cycle, STALL_LIMIT=16 -> stall_err=1 after the 16th identical retirement, instr_count=16.
- Coincidence: HALT_INSTR retired on the cycle cycle_count hits MAX_CYCLES -> halt_hit=1, timeout=0. Then a start in DONE reruns with counters cleared to 0.
- Mid-run reset: assert rst_n during RUN at cycle 50 -> next edge IDLE, all outputs at reset values, core_rst=1; start afterwards behaves as a fresh run.
